// File: rtl/izh_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed Izhikevich neuron array.
package izh_pkg;

  // Fixed-point terms of dv = 0.04*v^2 + 5v + 140 - u + I (0.04 ~= 41/1024)
  localparam int BIAS_INT  = 140;
  localparam int VSQ_COEF  = 41;
  localparam int VSQ_SHIFT = 10;

  localparam int DEF_V_PEAK  = 7680;    // 30.0
  localparam int DEF_C_RESET = -16640;  // -65.0
  localparam int DEF_D_INC   = 2048;    // 8.0
  localparam int DEF_V_INIT  = -16640;
  localparam int DEF_U_INIT  = -4160;

  localparam int GUARD_BITS   = 8;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/izh_if.sv
// Step handshake, current fetch port and spike event port of the neuron array.
interface izh_if #(
  parameter int N_NEURONS = 16,
  parameter int WIDTH     = 32
);
  localparam int AW = $clog2(N_NEURONS);

  logic                    step_start;
  logic                    busy;
  logic                    done;
  logic [AW-1:0]           i_addr;
  logic signed [WIDTH-1:0] i_data;
  logic                    spike_valid;
  logic [AW-1:0]           spike_idx;

  modport master (
    input  step_start, i_data,
    output busy, done, i_addr, spike_valid, spike_idx
  );

  modport slave (
    output step_start, i_data,
    input  busy, done, i_addr, spike_valid, spike_idx
  );
endinterface

// File: rtl/izh_update.sv
// Combinational stage-2 Euler update of one neuron: v/u update, spike decision and,
// when IZH_REFRACTORY_EN is defined, refractory gating of current and spikes.
module izh_update
  import izh_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 8,
  parameter int A_SHIFT = 6,
  parameter int B_SHIFT = 2,
  parameter int V_PEAK  = DEF_V_PEAK,
  parameter int C_RESET = DEF_C_RESET,
  parameter int D_INC   = DEF_D_INC
`ifdef IZH_REFRACTORY_EN
  , parameter int REFRACT_STEPS = 2
`endif
) (
  input  logic signed [WIDTH-1:0]            v,
  input  logic signed [WIDTH-1:0]            u,
  input  logic signed [WIDTH-1:0]            i_data,
  input  logic signed [WIDTH+GUARD_BITS-1:0] vsq,
`ifdef IZH_REFRACTORY_EN
  input  logic [$clog2(REFRACT_STEPS+1)-1:0] ref_cnt,
  output logic [$clog2(REFRACT_STEPS+1)-1:0] ref_cnt_new,
`endif
  output logic signed [WIDTH-1:0]            v_wb,
  output logic signed [WIDTH-1:0]            u_wb,
  output logic                               spike
);
  localparam int IW = WIDTH + GUARD_BITS;

  logic signed [IW-1:0] vx, ux, ix, v_new, u_new;
  logic                 refr;

  // NOTE: every signal below is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    vx = IW'(v);
    ux = IW'(u);
`ifdef IZH_REFRACTORY_EN
    refr = (ref_cnt != '0);
`else
    refr = 1'b0;
`endif
    ix    = refr ? '0 : IW'(i_data);
    v_new = vx + vsq + IW'(5) * vx + (IW'(BIAS_INT) <<< FRAC) - ux + ix;
    u_new = ux + (((vx >>> B_SHIFT) - ux) >>> A_SHIFT);
    spike = !refr && (v_new >= IW'(V_PEAK));
    v_wb  = spike ? WIDTH'(C_RESET) : WIDTH'(v_new);
    u_wb  = spike ? WIDTH'(u_new + IW'(D_INC)) : WIDTH'(u_new);
`ifdef IZH_REFRACTORY_EN
    if (spike)     ref_cnt_new = ($clog2(REFRACT_STEPS+1))'(REFRACT_STEPS);
    else if (refr) ref_cnt_new = ref_cnt - 1'b1;
    else           ref_cnt_new = ref_cnt;
`endif
  end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: FSM, 3-stage update pipeline and per-neuron state.
// Optional refractory counters are built when IZH_REFRACTORY_EN is defined.
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 16,
  parameter int WIDTH     = 32,
  parameter int FRAC      = 8,
  parameter int A_SHIFT   = 6,
  parameter int B_SHIFT   = 2,
  parameter int V_PEAK    = DEF_V_PEAK,
  parameter int C_RESET   = DEF_C_RESET,
  parameter int D_INC     = DEF_D_INC,
  parameter int V_INIT    = DEF_V_INIT,
  parameter int U_INIT    = DEF_U_INIT
`ifdef IZH_REFRACTORY_EN
  , parameter int REFRACT_STEPS = 2
`endif
) (
  input  logic clk,
  input  logic rst,
  izh_if.master bus
);
  localparam int AW = $clog2(N_NEURONS);
  localparam int IW = WIDTH + GUARD_BITS;

  state_t     state;
  logic [1:0] drain_cnt;

  logic signed [WIDTH-1:0] v_mem [N_NEURONS];
  logic signed [WIDTH-1:0] u_mem [N_NEURONS];

  logic                    s1_valid, s2_valid;
  logic [AW-1:0]           s1_idx, s2_idx;
  logic signed [WIDTH-1:0] s1_v, s1_u, s2_v, s2_u, s2_i;
  logic signed [IW-1:0]    s1_vx, vsq_c, s2_vsq;
  logic signed [WIDTH-1:0] v_wb, u_wb;
  logic                    spike;

`ifdef IZH_REFRACTORY_EN
  localparam int RW = $clog2(REFRACT_STEPS+1);
  logic [RW-1:0] r_mem [N_NEURONS];
  logic [RW-1:0] s1_r, s2_r, r_wb;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.i_addr <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.step_start) begin
            state      <= ST_RUN;
            bus.busy   <= 1'b1;
            bus.i_addr <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.i_addr == AW'(N_NEURONS-1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            bus.i_addr <= bus.i_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'(DRAIN_CYCLES-1)) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s1_vx = IW'(s1_v);
  assign vsq_c = (s1_vx * s1_vx * IW'(VSQ_COEF)) >>> (VSQ_SHIFT + FRAC);

  // NOTE: the state arrays are flop-based and must come out of reset at V_INIT/U_INIT, so they are reset here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      s1_idx          <= '0;
      s2_idx          <= '0;
      s1_v            <= '0;
      s1_u            <= '0;
      s2_v            <= '0;
      s2_u            <= '0;
      s2_i            <= '0;
      s2_vsq          <= '0;
      bus.spike_valid <= 1'b0;
      bus.spike_idx   <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= WIDTH'(V_INIT);
        u_mem[k] <= WIDTH'(U_INIT);
`ifdef IZH_REFRACTORY_EN
        r_mem[k] <= '0;
`endif
      end
`ifdef IZH_REFRACTORY_EN
      s1_r <= '0;
      s2_r <= '0;
`endif
    end else begin
      s1_valid <= (state == ST_RUN);
      s1_idx   <= bus.i_addr;
      s1_v     <= v_mem[bus.i_addr];
      s1_u     <= u_mem[bus.i_addr];
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_v     <= s1_v;
      s2_u     <= s1_u;
      s2_vsq   <= vsq_c;
      s2_i     <= bus.i_data;
`ifdef IZH_REFRACTORY_EN
      s1_r <= r_mem[bus.i_addr];
      s2_r <= s1_r;
`endif
      bus.spike_valid <= s2_valid && spike;
      if (s2_valid && spike) bus.spike_idx <= s2_idx;
      if (s2_valid) begin
        v_mem[s2_idx] <= v_wb;
        u_mem[s2_idx] <= u_wb;
`ifdef IZH_REFRACTORY_EN
        r_mem[s2_idx] <= r_wb;
`endif
      end
    end
  end

  izh_update #(
    .WIDTH   (WIDTH),
    .FRAC    (FRAC),
    .A_SHIFT (A_SHIFT),
    .B_SHIFT (B_SHIFT),
    .V_PEAK  (V_PEAK),
    .C_RESET (C_RESET),
    .D_INC   (D_INC)
`ifdef IZH_REFRACTORY_EN
    , .REFRACT_STEPS (REFRACT_STEPS)
`endif
  ) u_update (
    .v           (s2_v),
    .u           (s2_u),
    .i_data      (s2_i),
    .vsq         (s2_vsq),
`ifdef IZH_REFRACTORY_EN
    .ref_cnt     (s2_r),
    .ref_cnt_new (r_wb),
`endif
    .v_wb        (v_wb),
    .u_wb        (u_wb),
    .spike       (spike)
  );

endmodule
